// File: rtl/uart_loader_pkg.sv
// ============================================================================
// Module : uart_loader_pkg
// Brief  : Shared types, default command bytes and sizing helpers for the loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_FETCH   = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_SEND = 3'd6
    } state_e;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;
    localparam logic [7:0] CMD_READ_DEF  = 8'h0B;
    localparam logic [7:0] CMD_FETCH_DEF = 8'h01;

    // Byte count of a bus field (address or data word).
    function automatic int bytes_in(input int width);
        return width / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_loader_ser.sv
// ============================================================================
// Module : uart_loader_ser
// Brief  : Loads one data word and emits it MSB-first as valid/ready bytes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_loader_ser
    import uart_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              tx_ready_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    output logic              done_o
);

    localparam int NB   = bytes_in(DATA_W);
    localparam int CN_W = $clog2(NB + 1);

    logic [DATA_W-1:0] sh_q;
    logic [CN_W-1:0]   cnt_q;
    logic              act_q;
    logic              xfer;

    assign xfer       = act_q && tx_ready_i;
    assign tx_valid_o = act_q;
    assign tx_data_o  = sh_q[DATA_W-1 -: 8];
    assign done_o     = xfer && (cnt_q == CN_W'(NB - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (load_i) begin
            sh_q  <= word_i;
            cnt_q <= '0;
            act_q <= 1'b1;
        end else if (xfer) begin
            sh_q  <= sh_q << 8;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                act_q <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_burst_loader.sv
// ============================================================================
// Module : uart_burst_loader
// Brief  : Parses UART command frames into burst writes/reads on a req/gnt bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_burst_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter int         BURST_WORDS    = 4,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_READ       = CMD_READ_DEF,
    parameter logic [7:0] CMD_FETCH      = CMD_FETCH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_data_i,
    output logic                tx_valid_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_ready_i,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                fetch_en_o,
    output logic                busy_o,
    output logic                err_o,
    output logic                overrun_o
);

    localparam int NB   = bytes_in(DATA_W);
    localparam int AB   = bytes_in(ADDR_W);
    localparam int BC_W = $clog2(((AB > NB) ? AB : NB) + 1);
    localparam int WC_W = $clog2(BURST_WORDS + 1);
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, haddr_q;
    logic [DATA_W-1:0] wbuf_q, hdata_q;
    logic [BC_W-1:0]   bcnt_q;
    logic [WC_W-1:0]   wcnt_q;
    logic [TC_W-1:0]   tmo_q;
    logic              is_rd_q, wr_pend_q, err_q, ovr_q, fetch_q;

    logic              cmd_burst, addr_last, byte_last, word_last;
    logic              timed, tmo_hit, ser_load, ser_done;
    logic [DATA_W-1:0] word_next;

    assign cmd_burst = (rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ);
    assign addr_last = (bcnt_q == BC_W'(AB - 1));
    assign byte_last = (bcnt_q == BC_W'(NB - 1));
    assign word_last = (wcnt_q == WC_W'(BURST_WORDS - 1));
    assign timed     = (state_q == ST_ADDR) || (state_q == ST_WDATA) || (state_q == ST_FETCH);
    assign tmo_hit   = timed && !rx_valid_i && (tmo_q == TC_W'(TIMEOUT_CYCLES - 1));
    assign word_next = (wbuf_q << 8) | DATA_W'(rx_data_i);
    assign ser_load  = (state_q == ST_RD_WAIT) && mem_rvalid_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && cmd_burst) begin
                    state_d = ST_ADDR;
                end else if (rx_valid_i && (rx_data_i == CMD_FETCH)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ADDR: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (rx_valid_i && addr_last) begin
                    state_d = is_rd_q ? ST_RD_REQ : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (tmo_hit || (rx_valid_i && byte_last && word_last)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (tmo_hit || rx_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (!wr_pend_q && mem_gnt_i) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_RD_SEND;
                end
            end
            ST_RD_SEND: begin
                if (ser_done) begin
                    state_d = word_last ? ST_IDLE : ST_RD_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending write owns the bus; reads only request once it has drained.
    always_comb begin
        mem_req_o   = wr_pend_q || ((state_q == ST_RD_REQ) && !wr_pend_q);
        mem_we_o    = wr_pend_q;
        mem_addr_o  = wr_pend_q ? haddr_q : addr_q;
        mem_wdata_o = hdata_q;
        mem_be_o    = '1;
        busy_o      = (state_q != ST_IDLE) || wr_pend_q;
        err_o       = err_q;
        overrun_o   = ovr_q;
        fetch_en_o  = fetch_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            haddr_q   <= '0;
            wbuf_q    <= '0;
            hdata_q   <= '0;
            bcnt_q    <= '0;
            wcnt_q    <= '0;
            tmo_q     <= '0;
            is_rd_q   <= 1'b0;
            wr_pend_q <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            fetch_q   <= 1'b0;
        end else begin
            tmo_q <= (timed && !rx_valid_i && !tmo_hit) ? tmo_q + 1'b1 : '0;
            if (wr_pend_q && mem_gnt_i) begin
                wr_pend_q <= 1'b0;
            end
            if (tmo_hit) begin
                err_q  <= 1'b1;
                bcnt_q <= '0;
                wbuf_q <= '0;
            end
            if (rx_valid_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_burst) begin
                            is_rd_q <= (rx_data_i == CMD_READ);
                            bcnt_q  <= '0;
                            wcnt_q  <= '0;
                        end else if (rx_data_i != CMD_FETCH) begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= (addr_q << 8) | ADDR_W'(rx_data_i);
                        bcnt_q <= addr_last ? '0 : bcnt_q + 1'b1;
                    end
                    ST_WDATA: begin
                        wbuf_q <= word_next;
                        bcnt_q <= byte_last ? '0 : bcnt_q + 1'b1;
                        if (byte_last) begin
                            addr_q <= addr_q + ADDR_W'(NB);
                            wcnt_q <= wcnt_q + 1'b1;
                            // A grant in this same cycle frees the holding register.
                            if (wr_pend_q && !mem_gnt_i) begin
                                ovr_q <= 1'b1;
                            end else begin
                                haddr_q   <= addr_q;
                                hdata_q   <= word_next;
                                wr_pend_q <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: fetch_q <= rx_data_i[0];
                    default:  err_q   <= 1'b1;
                endcase
            end
            if ((state_q == ST_RD_SEND) && ser_done) begin
                addr_q <= addr_q + ADDR_W'(NB);
                wcnt_q <= wcnt_q + 1'b1;
            end
        end
    end

    uart_loader_ser #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ser_load),
        .word_i     (mem_rdata_i),
        .tx_ready_i (tx_ready_i),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .done_o     (ser_done)
    );

endmodule

`default_nettype wire
